fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the PC register and a single-outstanding
// instruction memory request, buffering one instruction when decode stalls.
module fetch_ctrl #(
  parameter int PC_BITS   = 32,
  parameter int INST_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_BITS-1:0]   pc_cur_i,
  output logic                 pc_write_o,
  output logic [PC_BITS-1:0]   pc_next_o,
  output logic                 im_req_o,
  output logic                 im_read_o,
  output logic [PC_BITS-1:0]   im_addr_o,
  input  logic                 im_ready_i,
  input  logic [INST_BITS-1:0] im_rdata_i,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [PC_BITS-1:0]   redirect_pc_i,
  output logic                 inst_valid_o,
  output logic [INST_BITS-1:0] inst_o,
  output logic [PC_BITS-1:0]   inst_pc_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [INST_BITS-1:0] hold_inst_r;
  logic [PC_BITS-1:0]   hold_pc_r;
  logic [PC_BITS-1:0]   drop_addr_r;
  logic                 hold_load_s;
  logic                 drop_load_s;
  logic [PC_BITS-1:0]   pc_inc_s;

  assign pc_inc_s  = pc_cur_i + PC_BITS'(3'd4);
  assign im_read_o = im_req_o;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Stall hold buffer and address of the abandoned in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_inst_r <= '0;
      hold_pc_r   <= '0;
      drop_addr_r <= '0;
    end else begin
      if (hold_load_s) begin
        hold_inst_r <= im_rdata_i;
        hold_pc_r   <= pc_cur_i;
      end
      if (drop_load_s) begin
        drop_addr_r <= pc_cur_i;
      end
    end
  end

  // Next-state and output decode; reset masks everything so nothing leaks out combinationally
  always_comb begin
    state_s      = state_r;
    pc_write_o   = 1'b0;
    pc_next_o    = '0;
    im_req_o     = 1'b0;
    im_addr_o    = '0;
    inst_valid_o = 1'b0;
    inst_o       = '0;
    inst_pc_o    = '0;
    hold_load_s  = 1'b0;
    drop_load_s  = 1'b0;
    if (rst) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = REQ;
          if (redirect_i) begin
            pc_write_o = 1'b1;
            pc_next_o  = redirect_pc_i;
          end else begin
            pc_write_o = 1'b0;
          end
        end
        REQ: begin
          im_req_o     = 1'b1;
          im_addr_o    = pc_cur_i;
          inst_valid_o = im_ready_i & ~redirect_i;
          inst_o       = im_rdata_i;
          inst_pc_o    = pc_cur_i;
          if (redirect_i) begin
            pc_write_o = 1'b1;
            pc_next_o  = redirect_pc_i;
            if (im_ready_i) begin
              state_s = REQ;
            end else begin
              // The memory still owes us this beat; remember its address to keep the bus stable
              state_s     = DROP;
              drop_load_s = 1'b1;
            end
          end else if (im_ready_i) begin
            if (stall_i) begin
              hold_load_s = 1'b1;
              state_s     = HOLD;
            end else begin
              pc_write_o = 1'b1;
              pc_next_o  = pc_inc_s;
              state_s    = REQ;
            end
          end else begin
            state_s = REQ;
          end
        end
        HOLD: begin
          inst_o    = hold_inst_r;
          inst_pc_o = hold_pc_r;
          if (redirect_i) begin
            inst_valid_o = 1'b0;
            pc_write_o   = 1'b1;
            pc_next_o    = redirect_pc_i;
            state_s      = REQ;
          end else if (!stall_i) begin
            inst_valid_o = 1'b1;
            pc_write_o   = 1'b1;
            pc_next_o    = pc_inc_s;
            state_s      = REQ;
          end else begin
            inst_valid_o = 1'b1;
            state_s      = HOLD;
          end
        end
        DROP: begin
          im_req_o  = 1'b1;
          im_addr_o = drop_addr_r;
          if (redirect_i) begin
            pc_write_o = 1'b1;
            pc_next_o  = redirect_pc_i;
          end else begin
            pc_write_o = 1'b0;
          end
          if (im_ready_i) begin
            state_s = REQ;
          end else begin
            state_s = DROP;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; models the PC register externally
// and checks combinational outputs mid-cycle against hand-computed values.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_cur;
  logic        pc_write_o;
  logic [31:0] pc_next_o;
  logic        im_req_o;
  logic        im_read_o;
  logic [31:0] im_addr_o;
  logic        im_ready_i;
  logic [31:0] im_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        pc_load;
  logic [31:0] pc_load_val;
  int          checks;
  int          errors;

  fetch_ctrl #(.PC_BITS(32), .INST_BITS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_cur_i     (pc_cur),
    .pc_write_o   (pc_write_o),
    .pc_next_o    (pc_next_o),
    .im_req_o     (im_req_o),
    .im_read_o    (im_read_o),
    .im_addr_o    (im_addr_o),
    .im_ready_i   (im_ready_i),
    .im_rdata_i   (im_rdata_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register; the bench may preload it to set up a scenario
  always @(posedge clk) begin
    if (pc_load) pc_cur <= pc_load_val;
    else if (pc_write_o) pc_cur <= pc_next_o;
  end

  task automatic test_reset;
    rst = 1'b1; pc_load = 1'b1; pc_load_val = 32'h0;
    im_ready_i = 1'b0; im_rdata_i = 32'h0; stall_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0400;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (im_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %0h exp 0", im_req_o); end
    checks++; if (im_read_o !== 1'b0) begin errors++; $display("FAIL rst_read got %0h exp 0", im_read_o); end
    checks++; if (pc_write_o !== 1'b0) begin errors++; $display("FAIL rst_pcw got %0h exp 0", pc_write_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", inst_valid_o); end
    @(negedge clk);
    rst = 1'b0; pc_load = 1'b0; redirect_i = 1'b0;
    #1;
    checks++; if (im_req_o !== 1'b0) begin errors++; $display("FAIL idle_req got %0h exp 0", im_req_o); end
    @(negedge clk); #1;
    checks++; if (im_req_o !== 1'b1 || im_addr_o !== 32'h0) begin errors++; $display("FAIL first_req got %0h/%h exp 1/00000000", im_req_o, im_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL first_valid got %0h exp 0", inst_valid_o); end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      im_ready_i = 1'b1; im_rdata_i = 32'h1000_0000 + 32'(i);
      #1;
      checks++;
      if (im_addr_o !== 32'(4 * i) || inst_valid_o !== 1'b1 || inst_o !== 32'h1000_0000 + 32'(i) ||
          inst_pc_o !== 32'(4 * i) || pc_write_o !== 1'b1 || pc_next_o !== 32'(4 * i + 4) || im_read_o !== 1'b1) begin
        errors++;
        $display("FAIL seq%0d got addr=%h v=%0h inst=%h ipc=%h pcw=%0h next=%h rd=%0h exp addr=%h v=1 inst=%h pcw=1 next=%h rd=1",
                 i, im_addr_o, inst_valid_o, inst_o, inst_pc_o, pc_write_o, pc_next_o, im_read_o,
                 32'(4 * i), 32'h1000_0000 + 32'(i), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_wait_states;
    @(negedge clk);
    im_ready_i = 1'b0; pc_load = 1'b1; pc_load_val = 32'h10;
    @(negedge clk);
    pc_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++;
      if (im_req_o !== 1'b1 || im_addr_o !== 32'h10 || pc_write_o !== 1'b0 || inst_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL wait%0d got req=%0h addr=%h pcw=%0h v=%0h exp 1/00000010/0/0", k, im_req_o, im_addr_o, pc_write_o, inst_valid_o);
      end
    end
    @(negedge clk);
    im_ready_i = 1'b1; im_rdata_i = 32'h0000_0013;
    #1;
    checks++;
    if (im_addr_o !== 32'h10 || pc_write_o !== 1'b1 || pc_next_o !== 32'h14 || inst_valid_o !== 1'b1 || inst_pc_o !== 32'h10) begin
      errors++;
      $display("FAIL wait_done got addr=%h pcw=%0h next=%h v=%0h ipc=%h exp 00000010/1/00000014/1/00000010",
               im_addr_o, pc_write_o, pc_next_o, inst_valid_o, inst_pc_o);
    end
  endtask

  task automatic test_stall_hold;
    @(negedge clk);
    im_ready_i = 1'b1; stall_i = 1'b1; im_rdata_i = 32'h00A0_0093;
    #1;
    checks++; if (inst_valid_o !== 1'b1 || pc_write_o !== 1'b0 || im_addr_o !== 32'h14) begin errors++; $display("FAIL stall_req got v=%0h pcw=%0h addr=%h exp 1/0/00000014", inst_valid_o, pc_write_o, im_addr_o); end
    @(negedge clk);
    im_ready_i = 1'b0; im_rdata_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (im_req_o !== 1'b0 || im_read_o !== 1'b0 || pc_write_o !== 1'b0) begin errors++; $display("FAIL hold_req got req=%0h rd=%0h pcw=%0h exp 0/0/0", im_req_o, im_read_o, pc_write_o); end
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00A0_0093 || inst_pc_o !== 32'h14) begin errors++; $display("FAIL hold_data got v=%0h inst=%h ipc=%h exp 1/00a00093/00000014", inst_valid_o, inst_o, inst_pc_o); end
    @(negedge clk);
    stall_i = 1'b0;
    #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h00A0_0093 || pc_write_o !== 1'b1 || pc_next_o !== 32'h18) begin errors++; $display("FAIL hold_release got v=%0h inst=%h pcw=%0h next=%h exp 1/00a00093/1/00000018", inst_valid_o, inst_o, pc_write_o, pc_next_o); end
    @(negedge clk); #1;
    checks++; if (im_req_o !== 1'b1 || im_addr_o !== 32'h18 || pc_write_o !== 1'b0) begin errors++; $display("FAIL hold_next got req=%0h addr=%h pcw=%0h exp 1/00000018/0", im_req_o, im_addr_o, pc_write_o); end
  endtask

  task automatic test_redirect_drop;
    @(negedge clk);
    pc_load = 1'b1; pc_load_val = 32'h20;
    @(negedge clk);
    pc_load = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    #1;
    checks++; if (pc_write_o !== 1'b1 || pc_next_o !== 32'h100 || inst_valid_o !== 1'b0 || im_addr_o !== 32'h20) begin errors++; $display("FAIL redir_req got pcw=%0h next=%h v=%0h addr=%h exp 1/00000100/0/00000020", pc_write_o, pc_next_o, inst_valid_o, im_addr_o); end
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    checks++; if (im_req_o !== 1'b1 || im_addr_o !== 32'h20 || inst_valid_o !== 1'b0 || pc_write_o !== 1'b0) begin errors++; $display("FAIL drop_wait got req=%0h addr=%h v=%0h pcw=%0h exp 1/00000020/0/0", im_req_o, im_addr_o, inst_valid_o, pc_write_o); end
    @(negedge clk);
    im_ready_i = 1'b1; im_rdata_i = 32'hBAD0_BAD0;
    #1;
    checks++; if (im_addr_o !== 32'h20 || inst_valid_o !== 1'b0 || pc_write_o !== 1'b0) begin errors++; $display("FAIL drop_late got addr=%h v=%0h pcw=%0h exp 00000020/0/0", im_addr_o, inst_valid_o, pc_write_o); end
    @(negedge clk);
    im_ready_i = 1'b0;
    #1;
    checks++; if (im_req_o !== 1'b1 || im_addr_o !== 32'h100 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL drop_next got req=%0h addr=%h v=%0h exp 1/00000100/0", im_req_o, im_addr_o, inst_valid_o); end
  endtask

  task automatic test_hold_redirect;
    @(negedge clk);
    im_ready_i = 1'b1; stall_i = 1'b1; im_rdata_i = 32'h1234_5678;
    #1;
    checks++; if (inst_valid_o !== 1'b1 || pc_write_o !== 1'b0) begin errors++; $display("FAIL hr_capture got v=%0h pcw=%0h exp 1/0", inst_valid_o, pc_write_o); end
    @(negedge clk);
    im_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    #1;
    checks++; if (inst_valid_o !== 1'b0 || pc_write_o !== 1'b1 || pc_next_o !== 32'h200 || im_req_o !== 1'b0) begin errors++; $display("FAIL hr_redir got v=%0h pcw=%0h next=%h req=%0h exp 0/1/00000200/0", inst_valid_o, pc_write_o, pc_next_o, im_req_o); end
    @(negedge clk);
    redirect_i = 1'b0; stall_i = 1'b0;
    #1;
    checks++; if (im_req_o !== 1'b1 || im_addr_o !== 32'h200 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL hr_next got req=%0h addr=%h v=%0h exp 1/00000200/0", im_req_o, im_addr_o, inst_valid_o); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    pc_load = 1'b1; pc_load_val = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_load = 1'b0; im_ready_i = 1'b1; im_rdata_i = 32'h0000_0013;
    #1;
    checks++; if (im_addr_o !== 32'hFFFF_FFFC || pc_write_o !== 1'b1 || pc_next_o !== 32'h0) begin errors++; $display("FAIL wrap got addr=%h pcw=%0h next=%h exp fffffffc/1/00000000", im_addr_o, pc_write_o, pc_next_o); end
    @(negedge clk);
    im_ready_i = 1'b0;
    #1;
    checks++; if (im_addr_o !== 32'h0 || im_req_o !== 1'b1) begin errors++; $display("FAIL wrap_next got addr=%h req=%0h exp 00000000/1", im_addr_o, im_req_o); end
  endtask

  task automatic test_reset_in_drop;
    @(negedge clk);
    pc_load = 1'b1; pc_load_val = 32'h80;
    @(negedge clk);
    pc_load = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h40;
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    checks++; if (im_req_o !== 1'b1 || im_addr_o !== 32'h80) begin errors++; $display("FAIL rd_drop got req=%0h addr=%h exp 1/00000080", im_req_o, im_addr_o); end
    #1;
    rst = 1'b1; pc_load = 1'b1; pc_load_val = 32'h0; redirect_i = 1'b1;
    #1;
    checks++; if (im_req_o !== 1'b0 || im_read_o !== 1'b0 || pc_write_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("FAIL rd_async got req=%0h rd=%0h pcw=%0h v=%0h exp 0/0/0/0", im_req_o, im_read_o, pc_write_o, inst_valid_o); end
    @(negedge clk);
    rst = 1'b0; pc_load = 1'b0; redirect_i = 1'b0;
    #1;
    checks++; if (im_req_o !== 1'b0) begin errors++; $display("FAIL rd_idle got %0h exp 0", im_req_o); end
    @(negedge clk);
    im_ready_i = 1'b1; im_rdata_i = 32'h0000_0055;
    #1;
    checks++; if (im_req_o !== 1'b1 || im_addr_o !== 32'h0 || inst_valid_o !== 1'b1 || inst_o !== 32'h55) begin errors++; $display("FAIL rd_fresh got req=%0h addr=%h v=%0h inst=%h exp 1/00000000/1/00000055", im_req_o, im_addr_o, inst_valid_o, inst_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_stall_hold();
    test_redirect_drop();
    test_hold_redirect();
    test_wrap();
    test_reset_in_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
